// File: rtl/cisc_instr_issuer.sv
// Program-buffered instruction issuer: streams stored instructions to a processor, one per cycle,
// and captures each result RES_LAT cycles later. Define ISSUER_CHECK_EN to add expected-result checking.
module cisc_instr_issuer #(
  parameter int          DEPTH      = 16,
  parameter int          RES_LAT    = 2,
  parameter logic [7:0]  NOP_OPCODE = 8'hFF,
  localparam int         AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [31:0]   prog_data,
  input  logic [7:0]    exp_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    opcode,
  output logic [7:0]    operand1,
  output logic [7:0]    operand2,
  output logic [7:0]    operand3,
  output logic          issue_valid,
  input  logic [7:0]    result_in,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW:0]   mismatch_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  localparam logic [AW:0] PC_ONE = 1;

  state_t               r_state;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_issueValid;
  logic [31:0]          r_instr;
  logic [AW:0]          r_pc;
  logic [AW:0]          r_len;
  logic [31:0]          r_prog [DEPTH];
  logic [7:0]           r_res  [DEPTH];
  logic [RES_LAT-1:0]   r_slotVld;
  logic [AW-1:0]        r_slotIdx [RES_LAT];

  logic                 w_accept;
  logic                 w_capture;
  logic [AW-1:0]        w_capIdx;
  logic [AW:0]          w_pcNext;
  logic                 w_lastIssue;
  logic                 w_earlyPending;

  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_capture   = r_slotVld[RES_LAT-1];
  assign w_capIdx    = r_slotIdx[RES_LAT-1];
  assign w_pcNext    = r_pc + PC_ONE;
  assign w_lastIssue = (w_pcNext == r_len);

  // Only the oldest slot may still be valid when leaving DRAIN; it captures on that same edge.
  always_comb begin
    w_earlyPending = 1'b0;
    for (int k = 0; k < RES_LAT - 1; k++) begin
      w_earlyPending = w_earlyPending | r_slotVld[k];
    end
  end

  always_ff @(posedge clk) begin
    if (prog_we && !r_busy) begin
      r_prog[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_res[w_capIdx] <= result_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_issueValid <= 1'b0;
      r_instr      <= {NOP_OPCODE, 24'h000000};
      r_pc         <= '0;
      r_len        <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (prog_len != '0) begin
              r_state      <= S_ISSUE;
              r_busy       <= 1'b1;
              r_pc         <= '0;
              r_len        <= prog_len;
              r_instr      <= r_prog[0];
              r_issueValid <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_lastIssue) begin
            r_state      <= S_DRAIN;
            r_issueValid <= 1'b0;
            r_instr      <= {NOP_OPCODE, 24'h000000};
          end else begin
            r_pc    <= w_pcNext;
            r_instr <= r_prog[w_pcNext[AW-1:0]];
          end
        end
        S_DRAIN: begin
          if (!w_earlyPending) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Each presented instruction enters the tracking pipe with its program index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slotVld <= '0;
      for (int k = 0; k < RES_LAT; k++) begin
        r_slotIdx[k] <= '0;
      end
    end else begin
      r_slotVld[0] <= r_issueValid;
      r_slotIdx[0] <= r_pc[AW-1:0];
      for (int k = 1; k < RES_LAT; k++) begin
        r_slotVld[k] <= r_slotVld[k-1];
        r_slotIdx[k] <= r_slotIdx[k-1];
      end
    end
  end

`ifdef ISSUER_CHECK_EN
  localparam logic [AW:0] CNT_MAX = DEPTH;

  logic [7:0]  r_exp [DEPTH];
  logic [AW:0] r_mismatch;

  always_ff @(posedge clk) begin
    if (prog_we && !r_busy) begin
      r_exp[prog_addr] <= exp_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch <= '0;
    end else if (w_accept) begin
      r_mismatch <= '0;
    end else if (w_capture && (result_in != r_exp[w_capIdx]) && (r_mismatch != CNT_MAX)) begin
      r_mismatch <= r_mismatch + PC_ONE;
    end
  end

  assign mismatch_cnt = r_mismatch;
`else
  logic w_unused;
  assign w_unused     = ^exp_data;
  assign mismatch_cnt = '0;
`endif

  assign busy        = r_busy;
  assign done        = r_done;
  assign issue_valid = r_issueValid;
  assign opcode      = r_instr[31:24];
  assign operand1    = r_instr[23:16];
  assign operand2    = r_instr[15:8];
  assign operand3    = r_instr[7:0];
  assign rd_data     = r_res[rd_addr];

endmodule

// File: tb/tb_cisc_instr_issuer.sv
// Self-checking bench for cisc_instr_issuer: a cycle-level behavioural model plus a small processor
// stand-in that returns ALU results RES_LAT cycles after each issue.
module tb_cisc_instr_issuer;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int RES_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0]   prog_data = '0;
  logic [7:0]    exp_data = '0;
  logic [AW:0]   prog_len = '0;
  logic          start = 1'b0;
  logic          busy, done, issue_valid;
  logic [7:0]    opcode, operand1, operand2, operand3;
  logic [7:0]    result_in = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [7:0]    rd_data;
  logic [AW:0]   mismatch_cnt;

  cisc_instr_issuer #(.DEPTH(DEPTH), .RES_LAT(RES_LAT), .NOP_OPCODE(8'hFF)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .exp_data(exp_data), .prog_len(prog_len), .start(start), .busy(busy), .done(done),
    .opcode(opcode), .operand1(operand1), .operand2(operand2), .operand3(operand3),
    .issue_valid(issue_valid), .result_in(result_in), .rd_addr(rd_addr), .rd_data(rd_data),
    .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: program/expected/result images and the currently running program.
  logic [31:0] mProg [DEPTH];
  logic [7:0]  mExp  [DEPTH];
  logic [7:0]  mRes  [DEPTH];
  bit          mResKnown [DEPTH];
  bit          active = 1'b0;
  int          startCyc = 0;
  int          runLen = 0;
  int          mCnt = 0;
  int          cyc = 0;
  bit          pendV [16];
  int          pendIdx [16];
  bit          schedV [8];
  logic [7:0]  schedD [8];
  int          issueCount = 0;
  int          donePulses = 0;

  function automatic logic [7:0] alu(input logic [31:0] ins);
    case (ins[31:24])
      8'h00:   alu = ins[23:16] + ins[15:8];
      8'h01:   alu = ins[23:16] - ins[15:8];
      8'h05:   alu = ~ins[23:16];
      default: alu = ins[23:16] ^ ins[15:8] ^ ins[7:0];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Processor stand-in and per-cycle comparison against the model, both mid-cycle.
  always @(negedge clk) begin : cmp
    int          rel;
    int          doneRel;
    int          j;
    bit          eValid, eBusy, eDone;
    logic [31:0] eIns;
    cyc++;
    if (issue_valid) begin
      schedV[(cyc + RES_LAT) % 8] = 1'b1;
      schedD[(cyc + RES_LAT) % 8] = alu({opcode, operand1, operand2, operand3});
    end
    if (schedV[cyc % 8]) begin
      result_in = schedD[cyc % 8];
      schedV[cyc % 8] = 1'b0;
    end else begin
      result_in = 8'($urandom);
    end

    rel = 0;
    doneRel = 0;
    if (rst) begin
      active = 1'b0;
      mCnt   = 0;
      for (int k = 0; k < 16; k++) pendV[k] = 1'b0;
      eValid = 1'b0; eBusy = 1'b0; eDone = 1'b0;
      eIns = 32'hFF000000;
    end else begin
      rel     = cyc - startCyc;
      doneRel = (runLen == 0) ? 1 : runLen + RES_LAT + 1;
      if (active && rel > doneRel) active = 1'b0;
      eValid = active && rel >= 1 && rel <= runLen;
      eIns   = eValid ? mProg[rel-1] : 32'hFF000000;
      eBusy  = active && runLen > 0 && rel >= 1 && rel <= runLen + RES_LAT;
      eDone  = active && rel == doneRel;
    end

    checkOutput("issue_valid", {31'd0, issue_valid}, {31'd0, eValid});
    checkOutput("instr", {opcode, operand1, operand2, operand3}, eIns);
    checkOutput("busy", {31'd0, busy}, {31'd0, eBusy});
    checkOutput("done", {31'd0, done}, {31'd0, eDone});
    checkOutput("mismatch_cnt", 32'(mismatch_cnt), 32'(mCnt));
    if ((!active || eDone) && mResKnown[rd_addr]) begin
      checkOutput("rd_data", {24'd0, rd_data}, {24'd0, mRes[rd_addr]});
    end
    if (issue_valid) issueCount++;
    if (done) donePulses++;

    if (!rst) begin
      if (eValid) begin
        pendV[(cyc + RES_LAT) % 16]   = 1'b1;
        pendIdx[(cyc + RES_LAT) % 16] = rel - 1;
      end
      if (pendV[cyc % 16]) begin
        j = pendIdx[cyc % 16];
        mRes[j] = alu(mProg[j]);
        mResKnown[j] = 1'b1;
`ifdef ISSUER_CHECK_EN
        if (mRes[j] != mExp[j] && mCnt < DEPTH) mCnt++;
`endif
        pendV[cyc % 16] = 1'b0;
      end
      if (prog_we && !eBusy) begin
        mProg[prog_addr] = prog_data;
        mExp[prog_addr]  = exp_data;
      end
      if (start && !active) begin
        active   = 1'b1;
        startCyc = cyc;
        runLen   = int'(prog_len);
        mCnt     = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int addr, input logic [31:0] data, input logic [7:0] expv);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = data;
    exp_data  = expv;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic runProgram(input int len, input bit junk);
    bit got;
    got = 1'b0;
    prog_len = (AW+1)'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      rd_addr = AW'($urandom);
      if (junk) begin
        prog_we   = 1'($urandom);
        prog_addr = AW'($urandom);
        prog_data = $urandom;
        exp_data  = 8'($urandom);
        start     = 1'($urandom);
      end
      tick();
    end
    if (!got) checkOutput("done_timeout", 32'd0, 32'd1);
    prog_we = 1'b0;
    start   = 1'b0;
    tick();
  endtask

  task automatic readLiteral(input string name, input int addr, input logic [7:0] expv);
    rd_addr = AW'(addr);
    #1;
    checkOutput(name, {24'd0, rd_data}, {24'd0, expv});
  endtask

  initial begin
    repeat (2) tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_opcode", {24'd0, opcode}, 32'hFF);
    checkOutput("reset_valid", {31'd0, issue_valid}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < DEPTH; i++) applyStimulus(i, $urandom, 8'($urandom));

    // Two-instruction add/sub program.
    applyStimulus(0, 32'h00050301, 8'h08);
    applyStimulus(1, 32'h01090402, 8'h05);
    issueCount = 0; donePulses = 0;
    runProgram(2, 1'b0);
    checkOutput("two_issue_cycles", 32'(issueCount), 32'd2);
    checkOutput("two_done_pulses", 32'(donePulses), 32'd1);
    readLiteral("two_res0", 0, 8'h08);
    readLiteral("two_res1", 1, 8'h05);
    checkOutput("two_mismatch", 32'(mismatch_cnt), 32'd0);

    // Empty program.
    issueCount = 0; donePulses = 0;
    runProgram(0, 1'b0);
    checkOutput("empty_issue_cycles", 32'(issueCount), 32'd0);
    checkOutput("empty_done_pulses", 32'(donePulses), 32'd1);
    readLiteral("empty_res0_kept", 0, 8'h08);

    // Full-depth program of NOT operations.
    for (int i = 0; i < DEPTH; i++) applyStimulus(i, {8'h05, 8'(i), 16'h0000}, 8'h00);
    issueCount = 0; donePulses = 0;
    runProgram(DEPTH, 1'b0);
    checkOutput("full_issue_cycles", 32'(issueCount), 32'd16);
    readLiteral("full_res0", 0, 8'hFF);
    readLiteral("full_res15", 15, 8'hF0);

    // Writes and starts while busy must be ignored.
    issueCount = 0; donePulses = 0;
    runProgram(DEPTH, 1'b1);
    checkOutput("junk_issue_cycles", 32'(issueCount), 32'd16);
    checkOutput("junk_done_pulses", 32'(donePulses), 32'd1);
    readLiteral("junk_res7", 7, 8'hF8);

    // Reset in the third issue cycle aborts the run.
    donePulses = 0;
    prog_len = 5'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort_opcode", {24'd0, opcode}, 32'hFF);
    checkOutput("abort_valid", {31'd0, issue_valid}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (25) tick();
    checkOutput("abort_no_done", 32'(donePulses), 32'd0);
    runProgram(5, 1'b0);
    checkOutput("after_abort_done", 32'(donePulses), 32'd1);

`ifdef ISSUER_CHECK_EN
    applyStimulus(0, 32'h00050301, 8'h08);
    applyStimulus(1, 32'h01090402, 8'h06);
    runProgram(2, 1'b0);
    checkOutput("check_mismatch_one", 32'(mismatch_cnt), 32'd1);
    runProgram(0, 1'b0);
    checkOutput("check_mismatch_cleared", 32'(mismatch_cnt), 32'd0);
`else
    checkOutput("mismatch_tied_zero", 32'(mismatch_cnt), 32'd0);
`endif

    // Randomized programs and lengths.
    for (int r = 0; r < 12; r++) begin
      int nw;
      nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++) begin
        applyStimulus($urandom_range(0, DEPTH-1),
                      {8'($urandom_range(0, 6)), 24'($urandom)}, 8'($urandom));
      end
      runProgram($urandom_range(0, DEPTH), 1'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
